pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the 8-bit-address core. It holds the architectural PC and issues one fetch request per instruction to instruction memory. It presents the returned instruction word to decode with a valid/ready handshake. On decode acceptance it loads the next address produced by the PC next-address adder (PC+4 or branch target), closing the loop between that adder and instruction memory.

---
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 tb/tb_pc_fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake and
// next-address loop. master = fetch unit, slave = memory/decode/adder side.
interface pc_fetch_unit_if #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [7:0]         next_pc;
    logic               imem_req;
    logic [7:0]         imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [7:0]         pc;
    logic [CNT_W-1:0]   fetch_count;
    logic               misalign_err;

    modport master (
        input  next_pc, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_valid, pc, fetch_count, misalign_err
    );

    modport slave (
        output next_pc, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_valid, pc, fetch_count, misalign_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> FETCH <-> VALID.
// Define PC_ALIGN_CHECK_EN to trap misaligned next_pc into a terminal FAULT state.
module pc_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         INSTR_W  = 32,
    parameter int         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
`ifdef PC_ALIGN_CHECK_EN
        , FAULT = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PC_ALIGN_CHECK_EN
    logic               err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
`ifdef PC_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = bus.next_pc;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FETCH;
`ifdef PC_ALIGN_CHECK_EN
                    // Faulting address still loads so software can see it.
                    if (bus.next_pc[1:0] != 2'b00) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = (state_q == FETCH) ? pc_q : 8'h00;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_count = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign_err = err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: fetched words are queued when memory
// responds and compared against instr/pc when decode accepts them.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.INSTR_W(32), .CNT_W(16)) bus ();

    pc_fetch_unit #(.RESET_PC(8'h00), .INSTR_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_pc;
    logic [15:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", {63'd0, bus.imem_req}, 64'd1);
    endtask

    // One full transaction: wait for request, memory wait states, response,
    // decode stall cycles, then accept with next address npc.
    task automatic fetch_one(input int wt, input logic [31:0] data, input int stall,
                             input logic [7:0] npc);
        sb_t e;
        wait_req();
        chk("imem_addr", {56'd0, bus.imem_addr}, {56'd0, exp_pc});
        bus.imem_ready = 1'b0;
        for (int i = 0; i < wt; i++) begin
            @(negedge clk);
            chk("wait_req", {63'd0, bus.imem_req}, 64'd1);
            chk("wait_valid", {63'd0, bus.instr_valid}, 64'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = data;
        sb_q.push_back('{pc: exp_pc, instr: data});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hBAD0BAD0;
        chk("valid_rise", {63'd0, bus.instr_valid}, 64'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_req", {63'd0, bus.imem_req}, 64'd0);
            chk("stall_instr", {32'd0, bus.instr}, {32'd0, data});
            chk("stall_pc", {56'd0, bus.pc}, {56'd0, exp_pc});
        end
        chk("sb_nonempty", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("acc_instr", {32'd0, bus.instr}, {32'd0, e.instr});
            chk("acc_pc", {56'd0, bus.pc}, {56'd0, e.pc});
        end
        bus.instr_ready = 1'b1;
        bus.next_pc     = npc;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        exp_pc  = npc;
        exp_cnt = exp_cnt + 16'd1;
        chk("acc_valid_fall", {63'd0, bus.instr_valid}, 64'd0);
        chk("acc_pc_load", {56'd0, bus.pc}, {56'd0, exp_pc});
        chk("acc_count", {48'd0, bus.fetch_count}, {48'd0, exp_cnt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.delete();
        exp_pc  = 8'h00;
        exp_cnt = 16'd0;
        chk("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, bus.instr}, 64'd0);
        chk("rst_pc", {56'd0, bus.pc}, 64'd0);
        chk("rst_count", {48'd0, bus.fetch_count}, 64'd0);
        chk("rst_req", {63'd0, bus.imem_req}, 64'd0);
        chk("rst_err", {63'd0, bus.misalign_err}, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.next_pc    = 8'h00;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // BOOT cycle idle, request in the second cycle after release
        chk("boot_req", {63'd0, bus.imem_req}, 64'd0);
        @(negedge clk);
        chk("first_req", {63'd0, bus.imem_req}, 64'd1);
        chk("first_addr", {56'd0, bus.imem_addr}, 64'd0);

        // Zero-wait stream, PC+4
        for (int i = 0; i < 4; i++) fetch_one(0, 32'h00000013, 0, exp_pc + 8'd4);
        chk("stream_count", {48'd0, bus.fetch_count}, 64'd4);
        chk("stream_pc", {56'd0, bus.pc}, 64'h10);

        // Branch at pc=10 to 40, with memory wait and decode stall
        fetch_one(3, 32'hDEADBEEF, 4, 8'h40);
        fetch_one(1, 32'hCAFEF00D, 2, 8'hFC);
        fetch_one(0, 32'h12345678, 0, 8'h00);
        wait_req();
        chk("wrap_addr", {56'd0, bus.imem_addr}, 64'h00);
        chk("wrap_err", {63'd0, bus.misalign_err}, 64'd0);

        // Reset mid-fetch with a response in the same cycle
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFFFFFF;
        rst_n = 1'b0;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        chk("mid_rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("mid_rst_instr", {32'd0, bus.instr}, 64'd0);
        chk("mid_rst_pc", {56'd0, bus.pc}, 64'd0);
        chk("mid_rst_count", {48'd0, bus.fetch_count}, 64'd0);
        do_reset();

        // Misaligned next_pc
        fetch_one(0, 32'h00000013, 1, 8'h06);
`ifdef PC_ALIGN_CHECK_EN
        chk("fault_err", {63'd0, bus.misalign_err}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_req", {63'd0, bus.imem_req}, 64'd0);
            chk("fault_valid", {63'd0, bus.instr_valid}, 64'd0);
            chk("fault_pc", {56'd0, bus.pc}, 64'h06);
        end
`else
        chk("misalign_err_off", {63'd0, bus.misalign_err}, 64'd0);
        fetch_one(0, 32'h0BADCAFE, 0, 8'h0A);
        chk("misalign_err_off2", {63'd0, bus.misalign_err}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
